// File: rtl/dmem_pipe_pkg.sv
// Load/store types shared by the LSU and the data memory, plus the load-side
// byte/half extraction helper used by both.
package ooop_types;

    typedef enum logic [1:0] {
        LS_B = 2'd0,
        LS_H = 2'd1,
        LS_W = 2'd2
    } ls_size_t;

    localparam int DMEM_TAG_W = 4;

    typedef struct packed {
        logic [DMEM_TAG_W-1:0] tag;
        logic                  err;
        logic [31:0]           rdata;
    } dmem_resp_t;

    // Select the addressed byte or half of a word and sign/zero extend it.
    function automatic logic [31:0] ld_extend(input logic [31:0] word,
                                              input ls_size_t    size,
                                              input logic [1:0]  off,
                                              input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            LS_B:    res = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            LS_H:    res = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_pipe_resp_fifo.sv
// Generic show-ahead FIFO: the head entry is always visible on rdata_o.
// Pointer and count state reset asynchronously; the storage array does not.
module dmem_resp_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return PW'((int'(p) + 1) % DEPTH);
    endfunction

    // A push into a full FIFO is only honoured when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/dmem_pipe.sv
// LSU data memory: valid/ready requests, fixed-latency response pipeline and a
// tagged, in-order response queue with backpressure and credit-based flow control.
module dmem_pipe
    import ooop_types::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int TAG_W       = 4,
    parameter int RESP_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    input  ls_size_t         req_size_i,
    input  logic             req_unsigned_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_rdata_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             resp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int RW = TAG_W + 1 + 32;
    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic [31:0]    mem [DEPTH_WORDS];
    logic [AW-1:0]  widx;
    logic [1:0]     off;
    logic           accept;
    logic           req_err;
    logic           wr_en;
    logic [3:0]     wr_be;
    logic [31:0]    wr_data;
    logic [31:0]    rd_word;
    logic [RW-1:0]  s0_data;
    logic           push;
    logic [RW-1:0]  push_data;
    logic [RW-1:0]  head;
    logic           fifo_empty;
    logic           fifo_full;
    logic [CW-1:0]  fifo_count;
    logic           fifo_unused;
    logic           pop;
    logic [CW-1:0]  out_q, out_d;

    assign widx   = req_addr_i[AW+1:2];
    assign off    = req_addr_i[1:0];
    assign accept = req_valid_i && req_ready_o;

    // Credits cover both pipeline stages and queue slots, so the queue never overflows.
    assign req_ready_o = !rst && (out_q < CW'(RESP_DEPTH));

    always_comb begin
        req_err = ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH_WORDS));
        case (req_size_i)
            LS_H:    if (off[0]) req_err = 1'b1;
            LS_W:    if (off != 2'b00) req_err = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = req_wdata_i;
        case (req_size_i)
            LS_B: begin
                wr_be   = 4'b0001 << off;
                wr_data = {4{req_wdata_i[7:0]}};
            end
            LS_H: begin
                wr_be   = off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign wr_en = accept && req_we_i && !req_err;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read during the accept cycle so a load right after a store sees the new word.
    assign rd_word = mem[widx];
    assign s0_data = {req_tag_i, req_err,
                      (req_we_i || req_err) ? 32'h0
                                            : ld_extend(rd_word, req_size_i, off, req_unsigned_i)};

    generate
        if (LATENCY == 1) begin : g_nopipe
            assign push      = accept;
            assign push_data = s0_data;
        end else begin : g_pipe
            logic [LATENCY-2:0] vld_q;
            logic [RW-1:0]      dat_q [LATENCY-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= accept;
                    dat_q[0] <= s0_data;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign push      = vld_q[LATENCY-2];
            assign push_data = dat_q[LATENCY-2];
        end
    endgenerate

    dmem_resp_fifo #(
        .WIDTH (RW),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fifo_unused = fifo_full ^ (^fifo_count);

    assign resp_valid_o = !fifo_empty;
    assign pop          = resp_valid_o && resp_ready_i;
    assign resp_tag_o   = resp_valid_o ? head[RW-1 -: TAG_W] : '0;
    assign resp_err_o   = resp_valid_o ? head[32] : 1'b0;
    assign resp_rdata_o = resp_valid_o ? head[31:0] : 32'h0;

    always_comb begin
        out_d = out_q;
        if (accept && !pop) begin
            out_d = out_q + 1'b1;
        end else if (!accept && pop) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
Parametrised data memory for the LSU path, and the next generation of the fixed-latency BRAM data memory.
- Adds a valid/ready request handshake, a configurable read latency and a tagged response channel with backpressure.
- Adds load-side byte/half extraction with sign/zero extension, and error reporting for misaligned or out-of-range accesses.
- Sits between the LSU issue stage and the memory-response writeback, with multiple requests outstanding.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- LATENCY, 2, accept-to-response cycles when the response queue is empty and unstalled; legal range is 1 or greater.
- TAG_W, 4, width of the request tag returned with the response.
- RESP_DEPTH, 4, maximum outstanding requests (in pipeline plus queued); must be 1 or greater.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request can be accepted this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- req_size_i  in  ooop_types::ls_size_t  LS_B, LS_H or LS_W.
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- req_tag_i  in  TAG_W  tag, returned unchanged in the response.
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  consumer takes the response.
- resp_rdata_o  out  32  load data, extended; 0 for stores and for errors.
- resp_tag_o  out  TAG_W  tag of the request this response belongs to.
- resp_err_o  out  1  request was misaligned or out of range.

Behaviour:
- Accept: a request is accepted on a rising edge when req_valid_i && req_ready_o.
- Ready: req_ready_o = (outstanding < RESP_DEPTH), purely from registered state.
- Outstanding counter:
  - +1 on accept, -1 on response handshake (resp_valid_o && resp_ready_i), unchanged when both happen in the same cycle.
  - Never exceeds RESP_DEPTH, so the queue cannot overflow.
- Error detection (resp_err_o = 1 when any holds):
  - LS_H with addr[0] = 1.
  - LS_W with addr[1:0] != 0.
  - addr[31:2] >= DEPTH_WORDS.
  - An erroring access performs no write and returns rdata 0.
- Stores: memory is updated at the accept edge with byte/half/word merge at offset addr[1:0]; the response still flows through the pipeline with rdata 0.
- Loads:
  - The word is read at the accept edge.
  - Byte is selected by addr[1:0]; half by addr[1].
  - The selected field is sign- or zero-extended per req_unsigned_i, carried as a registered pipeline field.
- Ordering:
  - A load accepted the cycle after a store to the same word returns the new data.
  - Responses return strictly in accept order.
- Pipeline: LATENCY-1 register stages carry {valid, tag, err, rdata}; stage LATENCY pushes into the response queue.
- Timing: a request accepted at edge E produces resp_valid_o in the cycle after edge E+LATENCY-1 if the queue was empty, i.e. visible LATENCY cycles after the accept cycle.
- Response queue:
  - Show-ahead FIFO, RESP_DEPTH entries.
  - The head drives resp_* combinationally.
  - Push and pop in the same cycle are legal, including when the queue is full, since the credit scheme guarantees a free slot.
- Backpressure: with resp_ready_i = 0, responses accumulate and req_ready_o drops once outstanding = RESP_DEPTH; the pipeline itself never stalls.
- Reset (asynchronous, any time, including mid-operation):
  - Clears pipeline valids, queue pointers and the outstanding counter.
  - Outputs during and after reset: resp_valid_o = 0, resp_tag_o = 0, resp_rdata_o = 0, resp_err_o = 0.
  - req_ready_o = 0 while rst is high, 1 from the first cycle after release.
  - In-flight requests are dropped; memory contents are not reset (BRAM inference).
- Counter and pointer widths: $clog2(RESP_DEPTH+1) and $clog2(RESP_DEPTH); wrap-around uses explicit modulo for non-power-of-two depths.

Decomposition:
- ooop_types:
  - Reuses ls_size_t.
  - Adds dmem_resp_t {tag, err, rdata} parametrised through a TAG_W localparam, or passed as a packed vector when TAG_W differs.
  - Adds function ld_extend(word, size, off, unsigned), shared with the LSU.
- One sub-module, dmem_resp_fifo: a generic synchronous show-ahead FIFO with WIDTH and DEPTH parameters, asynchronous active-high reset, and push/pop/full/empty/count.

Test Plan:
- Word store/load and extension:
  - SW 0xDEADBEEF at 0x10, then LW 0x10 -> rdata 0xDEADBEEF, err 0, response 2 cycles after accept (LATENCY = 2).
  - With memory[0x10] = 0xDEADBEEF:
    - LB 0x13 signed -> 0xFFFFFFDE.
    - LBU 0x13 -> 0x000000DE.
    - LH 0x12 -> 0xFFFFDEAD.
    - LHU 0x10 -> 0x0000BEEF.
- Byte merge: SB 0x55 at 0x11, then LW 0x10 -> 0xDEAD55EF; back-to-back store-then-load to the same word returns the updated data.
- Backpressure:
  - resp_ready_i = 0, issue 6 loads with tags 1..6 back-to-back.
  - req_ready_o falls after the 4th accept; tag 5 is held.
  - Raise resp_ready_i -> tags 1..6 return in order, with no loss or duplication.
- Error paths:
  - LW 0x11 -> err 1, rdata 0.
  - SH 0x0F -> err 1, memory unchanged.
  - LW at address 4*DEPTH_WORDS -> err 1.
- Reset mid-flight and parameter sweep:
  - Assert rst with 3 loads outstanding -> resp_valid_o = 0 immediately; after release, req_ready_o = 1 and no stale responses appear.
  - Repeat the first scenario with LATENCY = 1, 3 and 5 and check the exact response cycle.
